// File: rtl/game_pkg.sv
// Shared types and constants for the game controller: FSM states, move
// directions, datapath select codes and plot colours.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_DRAW  = 3'd2,
        S_TCLR  = 3'd3,
        S_WAIT  = 3'd4,
        S_POLL  = 3'd5,
        S_ERASE = 3'd6,
        S_MOVE  = 3'd7
    } state_e;

    // Encoding matches the key bit index of each button.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam int KEY_W = 4;
    localparam int POS_W = 8;

    localparam logic [1:0] SEL_INIT = 2'd0;
    localparam logic [1:0] SEL_INC  = 2'd1;
    localparam logic [1:0] SEL_DEC  = 2'd2;

    localparam logic COLOR_ERASE = 1'b0;
    localparam logic COLOR_DRAW  = 1'b1;

    function automatic logic dir_is_x(dir_e d);
        return (d == DIR_LEFT) || (d == DIR_RIGHT);
    endfunction

    // Right and down grow the coordinate; left and up shrink it.
    function automatic logic [1:0] dir_sel(dir_e d);
        return ((d == DIR_RIGHT) || (d == DIR_DOWN)) ? SEL_INC : SEL_DEC;
    endfunction

endpackage

// File: rtl/game_control_if.sv
// Signal bundle between the game controller and its drawing datapath.
// The master side is the datapath (drives keys/position), the slave is the controller.
interface game_control_if;
    logic       start;
    logic [3:0] key;
    logic       timer_done;
    logic [7:0] xpos;
    logic [7:0] ypos;
    logic       plot;
    logic       s_color;
    logic       en_timer;
    logic       s_timer;
    logic       en_xpos;
    logic       en_ypos;
    logic [1:0] s_xpos;
    logic [1:0] s_ypos;
    logic       busy;

    modport master (
        output start, key, timer_done, xpos, ypos,
        input  plot, s_color, en_timer, s_timer,
        input  en_xpos, en_ypos, s_xpos, s_ypos, busy
    );

    modport slave (
        input  start, key, timer_done, xpos, ypos,
        output plot, s_color, en_timer, s_timer,
        output en_xpos, en_ypos, s_xpos, s_ypos, busy
    );
endinterface

// File: rtl/key_arbiter.sv
// Combinational key priority (right > left > down > up) with range eligibility.
// GAME_CONTROL_KEY_REPEAT_EN: when undefined, only keys released at the previous poll count.
module key_arbiter
    import game_pkg::*;
#(
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic [KEY_W-1:0] key,
    input  logic [POS_W-1:0] xpos,
    input  logic [POS_W-1:0] ypos,
    input  logic [KEY_W-1:0] key_hist,
    output logic             valid,
    output dir_e             dir
);

    localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX);

    logic [KEY_W-1:0] cand;
    logic [KEY_W-1:0] elig;

`ifdef GAME_CONTROL_KEY_REPEAT_EN
    logic unused_hist;
    assign unused_hist = ^key_hist;
    assign cand        = key;
`else
    assign cand = key & ~key_hist;
`endif

    // A key that would push the position out of range drops out, letting a lower one win.
    assign elig[DIR_UP]    = cand[DIR_UP]    && (ypos != '0);
    assign elig[DIR_DOWN]  = cand[DIR_DOWN]  && (ypos <  Y_LIM);
    assign elig[DIR_LEFT]  = cand[DIR_LEFT]  && (xpos != '0);
    assign elig[DIR_RIGHT] = cand[DIR_RIGHT] && (xpos <  X_LIM);

    always_comb begin
        valid = 1'b0;
        dir   = DIR_UP;
        if (elig[DIR_RIGHT]) begin
            valid = 1'b1;
            dir   = DIR_RIGHT;
        end else if (elig[DIR_LEFT]) begin
            valid = 1'b1;
            dir   = DIR_LEFT;
        end else if (elig[DIR_DOWN]) begin
            valid = 1'b1;
            dir   = DIR_DOWN;
        end else if (elig[DIR_UP]) begin
            valid = 1'b1;
            dir   = DIR_UP;
        end
    end

endmodule

// File: rtl/game_control.sv
// Moore FSM sequencing draw / frame delay / key poll / erase / move for a one-pixel sprite.
// GAME_CONTROL_KEY_REPEAT_EN selects held-key repeat inside key_arbiter.
module game_control
    import game_pkg::*;
#(
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic             timer_done,
    input  logic [POS_W-1:0] xpos,
    input  logic [POS_W-1:0] ypos,
    output logic             plot,
    output logic             s_color,
    output logic             en_timer,
    output logic             s_timer,
    output logic             en_xpos,
    output logic             en_ypos,
    output logic [1:0]       s_xpos,
    output logic [1:0]       s_ypos,
    output logic             busy,
    output state_e           dbg_state
);

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [KEY_W-1:0] hist_q, hist_d;

    logic             arb_valid;
    dir_e             arb_dir;

    key_arbiter #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_key_arbiter (
        .key      (key),
        .xpos     (xpos),
        .ypos     (ypos),
        .key_hist (hist_q),
        .valid    (arb_valid),
        .dir      (arb_dir)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_UP;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            hist_q  <= hist_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        hist_d  = hist_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_INIT;
            S_INIT:  state_d = S_DRAW;
            S_DRAW:  state_d = S_TCLR;
            S_TCLR:  state_d = S_WAIT;
            S_WAIT:  if (timer_done) state_d = S_POLL;
            S_POLL: begin
                hist_d = key;
                if (arb_valid) begin
                    dir_d   = arb_dir;
                    state_d = S_ERASE;
                end else begin
                    state_d = S_TCLR;
                end
            end
            S_ERASE: state_d = S_MOVE;
            S_MOVE:  state_d = S_DRAW;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on state_q and dir_q, so an async reset clears them at once.
    always_comb begin
        plot     = 1'b0;
        s_color  = COLOR_ERASE;
        en_timer = 1'b0;
        s_timer  = 1'b0;
        en_xpos  = 1'b0;
        en_ypos  = 1'b0;
        s_xpos   = SEL_INIT;
        s_ypos   = SEL_INIT;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_INIT: begin
                en_xpos = 1'b1;
                en_ypos = 1'b1;
            end
            S_DRAW: begin
                plot    = 1'b1;
                s_color = COLOR_DRAW;
            end
            S_TCLR:  en_timer = 1'b1;
            S_WAIT: begin
                en_timer = 1'b1;
                s_timer  = 1'b1;
            end
            S_ERASE: plot = 1'b1;
            S_MOVE: begin
                if (dir_is_x(dir_q)) begin
                    en_xpos = 1'b1;
                    s_xpos  = dir_sel(dir_q);
                end else begin
                    en_ypos = 1'b1;
                    s_ypos  = dir_sel(dir_q);
                end
            end
            default: ;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_game_control.sv
// Scenario bench for game_control: expected output vectors are queued per cycle
// and popped against the DUT one clock at a time.
module tb_game_control;
  import game_pkg::*;

  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;
  localparam int OW    = 11;

  // Vector layout: busy plot s_color en_timer s_timer en_xpos s_xpos[2] en_ypos s_ypos[2]
  localparam logic [OW-1:0] O_IDLE = 11'b0_0_0_0_0_0_00_0_00;
  localparam logic [OW-1:0] O_INIT = 11'b1_0_0_0_0_1_00_1_00;
  localparam logic [OW-1:0] O_DRAW = 11'b1_1_1_0_0_0_00_0_00;
  localparam logic [OW-1:0] O_TCLR = 11'b1_0_0_1_0_0_00_0_00;
  localparam logic [OW-1:0] O_WAIT = 11'b1_0_0_1_1_0_00_0_00;
  localparam logic [OW-1:0] O_POLL = 11'b1_0_0_0_0_0_00_0_00;
  localparam logic [OW-1:0] O_ERAS = 11'b1_1_0_0_0_0_00_0_00;
  localparam logic [OW-1:0] O_MV_R = 11'b1_0_0_0_0_1_01_0_00;
  localparam logic [OW-1:0] O_MV_L = 11'b1_0_0_0_0_1_10_0_00;
  localparam logic [OW-1:0] O_MV_D = 11'b1_0_0_0_0_0_00_1_01;
  localparam logic [OW-1:0] O_MV_U = 11'b1_0_0_0_0_0_00_1_10;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  state_e dbg_state;
  int total = 0;
  int bad = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] e;
  logic [OW-1:0] outs;

  game_control_if gif();

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  game_control #(
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (gif.start),
    .key        (gif.key),
    .timer_done (gif.timer_done),
    .xpos       (gif.xpos),
    .ypos       (gif.ypos),
    .plot       (gif.plot),
    .s_color    (gif.s_color),
    .en_timer   (gif.en_timer),
    .s_timer    (gif.s_timer),
    .en_xpos    (gif.en_xpos),
    .en_ypos    (gif.en_ypos),
    .s_xpos     (gif.s_xpos),
    .s_ypos     (gif.s_ypos),
    .busy       (gif.busy),
    .dbg_state  (dbg_state)
  );

  assign outs = {gif.busy, gif.plot, gif.s_color, gif.en_timer, gif.s_timer,
                 gif.en_xpos, gif.s_xpos, gif.en_ypos, gif.s_ypos};

  // ---------------- driver tasks ----------------
  // Called at #1 after a clock edge while the FSM sits in WAIT.
  task automatic drive_poll(input logic [7:0] x, input logic [7:0] y, input logic [3:0] k);
    gif.xpos = x;
    gif.ypos = y;
    gif.key = k;
    gif.timer_done = 1'b1;
  endtask

  task automatic expect_poll(input bit moves, input logic [OW-1:0] mv);
    exp_q.push_back(O_POLL);
    if (moves) begin
      exp_q.push_back(O_ERAS);
      exp_q.push_back(mv);
      exp_q.push_back(O_DRAW);
    end
    exp_q.push_back(O_TCLR);
    exp_q.push_back(O_WAIT);
    exp_q.push_back(O_WAIT);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    gif.start = 1'b0;
    gif.key = 4'b0000;
    gif.timer_done = 1'b0;
    gif.xpos = 8'd0;
    gif.ypos = 8'd0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL reset_outs got=%b want=%b", outs, O_IDLE);
    end
    total++;
    if (dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL reset_state got=%0d want=%0d", dbg_state, S_IDLE);
    end
    resetn = 1'b1;
    repeat (3) exp_q.push_back(O_IDLE);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL idle_no_start cyc=%0d got=%b want=%b", n, outs, e);
      end
    end
  endtask

  task automatic test_start();
    gif.start = 1'b1;
    exp_q.push_back(O_INIT);
    exp_q.push_back(O_DRAW);
    exp_q.push_back(O_TCLR);
    repeat (4) exp_q.push_back(O_WAIT);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      // start is dropped after INIT and raised again while waiting; it must be ignored.
      gif.start = (n >= 3 && n < 5);
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL start_seq cyc=%0d got=%b want=%b", n, outs, e);
      end
    end
    gif.start = 1'b0;
    total++;
    if (dbg_state !== S_WAIT) begin
      bad++;
      $display("FAIL start_in_wait got=%0d want=%0d", dbg_state, S_WAIT);
    end
  endtask

  task automatic test_move_right();
    drive_poll(8'd80, 8'd100, 4'b1000);
    expect_poll(1'b1, O_MV_R);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      gif.timer_done = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL move_right cyc=%0d got=%b want=%b", n, outs, e);
      end
    end
  endtask

  task automatic test_boundary_priority();
    // Left is blocked at xpos=0, so up (lowest priority) wins.
    drive_poll(8'd0, 8'd5, 4'b0101);
    expect_poll(1'b1, O_MV_U);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      gif.timer_done = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL left_blocked_up cyc=%0d got=%b want=%b", n, outs, e);
      end
    end
  endtask

  task automatic test_blocked();
    drive_poll(8'(X_MAX), 8'd50, 4'b1000);
    expect_poll(1'b0, O_IDLE);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      gif.timer_done = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL right_at_xmax cyc=%0d got=%b want=%b", n, outs, e);
      end
    end
    drive_poll(8'd80, 8'(Y_MAX), 4'b0010);
    expect_poll(1'b0, O_IDLE);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      gif.timer_done = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL down_at_ymax cyc=%0d got=%b want=%b", n, outs, e);
      end
    end
  endtask

  task automatic test_key_hold();
    int moves;
    int exp_moves;
    moves = 0;
`ifdef GAME_CONTROL_KEY_REPEAT_EN
    exp_moves = 3;
`else
    exp_moves = 1;
`endif
    for (int p = 0; p < 3; p++) begin
      drive_poll(8'd80, 8'd100, 4'b1000);
      expect_poll((p < exp_moves), O_MV_R);
      for (int n = 0; exp_q.size() > 0; n++) begin
        @(posedge clk); #1;
        gif.timer_done = 1'b0;
        if (gif.en_xpos) moves++;
        e = exp_q.pop_front();
        total++;
        if (outs !== e) begin
          bad++;
          $display("FAIL key_hold p=%0d cyc=%0d got=%b want=%b", p, n, outs, e);
        end
      end
    end
    total++;
    if (moves !== exp_moves) begin
      bad++;
      $display("FAIL key_hold_moves got=%0d want=%0d", moves, exp_moves);
    end
  endtask

  task automatic test_opposite_keys();
    logic [3:0]    k_tab[3];
    logic [OW-1:0] m_tab[3];
    bit            v_tab[3];
    k_tab[0] = 4'b0000; v_tab[0] = 1'b0; m_tab[0] = O_IDLE;
    k_tab[1] = 4'b1100; v_tab[1] = 1'b1; m_tab[1] = O_MV_R;
    k_tab[2] = 4'b0011; v_tab[2] = 1'b1; m_tab[2] = O_MV_D;
    for (int p = 0; p < 3; p++) begin
      drive_poll(8'd80, 8'd100, k_tab[p]);
      expect_poll(v_tab[p], m_tab[p]);
      for (int n = 0; exp_q.size() > 0; n++) begin
        @(posedge clk); #1;
        gif.timer_done = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (outs !== e) begin
          bad++;
          $display("FAIL opposite p=%0d cyc=%0d got=%b want=%b", p, n, outs, e);
        end
      end
    end
  endtask

  task automatic test_reset_mid_move();
    drive_poll(8'd80, 8'd100, 4'b0100);
    exp_q.push_back(O_POLL);
    exp_q.push_back(O_ERAS);
    exp_q.push_back(O_MV_L);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      gif.timer_done = 1'b0;
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL pre_reset_move cyc=%0d got=%b want=%b", n, outs, e);
      end
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (outs !== O_IDLE) begin
      bad++;
      $display("FAIL async_reset_outs got=%b want=%b", outs, O_IDLE);
    end
    total++;
    if (dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL async_reset_state got=%0d want=%0d", dbg_state, S_IDLE);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    gif.key = 4'b0000;
    repeat (3) exp_q.push_back(O_IDLE);
    exp_q.push_back(O_INIT);
    exp_q.push_back(O_DRAW);
    for (int n = 0; exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
      gif.start = (n == 2);
      e = exp_q.pop_front();
      total++;
      if (outs !== e) begin
        bad++;
        $display("FAIL post_reset cyc=%0d got=%b want=%b", n, outs, e);
      end
    end
    gif.start = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_start();
    test_move_right();
    test_boundary_priority();
    test_blocked();
    test_key_hold();
    test_opposite_keys();
    test_reset_mid_move();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expectations got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_control.md
GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 SHALL have parameter X_MAX, default 159, meaning the largest legal xpos.
REQ-002 SHALL have parameter Y_MAX, default 119, meaning the largest legal ypos.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin play from IDLE.
REQ-006 SHALL have port key, input, 4 bits: synchronised active-high buttons; [0]=up, [1]=down, [2]=left, [3]=right.
REQ-007 SHALL have port timer_done, input, 1 bit: frame-delay expiry flag from the datapath.
REQ-008 SHALL have ports xpos and ypos, input, 8 bits each: current datapath position.
REQ-009 SHALL have ports plot, s_color, en_timer and s_timer, output, 1 bit each: datapath draw and timer controls.
REQ-010 SHALL have ports en_xpos and en_ypos, output, 1 bit each, plus s_xpos and s_ypos, output, 2 bits each; selects are 0=init, 1=+1, 2=-1.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, INIT, DRAW, TCLR, WAIT, POLL, ERASE and MOVE; all outputs decode from the state register and the registered move direction only.
REQ-013 IDLE SHALL drive all outputs to 0 and go to INIT when start=1.
REQ-014 INIT SHALL assert en_xpos=en_ypos=1 with s_xpos=s_ypos=0 for one cycle, then go to DRAW.
REQ-015 DRAW SHALL assert plot=1 and s_color=1 for exactly one cycle, then go to TCLR.
REQ-016 TCLR SHALL assert en_timer=1 and s_timer=0 for one cycle, then go to WAIT.
REQ-017 WAIT SHALL assert en_timer=1 and s_timer=1, and stay in WAIT until timer_done=1, then go to POLL.
REQ-018 POLL SHALL sample key, apply the priority right > left > down > up, and register the single winning direction.
REQ-019 POLL with no eligible key SHALL go to TCLR without any plot.
REQ-020 A direction SHALL be ineligible when it would leave range: left at xpos=0, right at xpos=X_MAX, up at ypos=0, down at ypos=Y_MAX; the next eligible lower-priority key SHALL then be used.
REQ-021 With an eligible key, POLL SHALL go to ERASE; ERASE SHALL assert plot=1 and s_color=0 for one cycle, then go to MOVE.
REQ-022 MOVE SHALL assert exactly one of en_xpos or en_ypos for one cycle, with select 1 for right/down and 2 for left/up, then go to DRAW.
REQ-023 Opposite keys pressed together SHALL resolve by priority and never cancel.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 plot and en_xpos/en_ypos SHALL never be asserted in the same cycle.
REQ-026 Move latency from timer_done=1 in WAIT SHALL be: POLL +1, ERASE +2, MOVE +3, DRAW +4.

Reset
REQ-027 resetn=0 SHALL asynchronously force state IDLE, clear the direction register and key-history register, and drive all outputs to 0 (busy=0).
REQ-028 Reset asserted mid-operation, including during ERASE or MOVE, SHALL abort with no further plot or position enable.
REQ-029 After resetn deasserts, the FSM SHALL leave IDLE only on start=1.

Configuration
REQ-030 Macro GAME_CONTROL_KEY_REPEAT_EN SHALL select the key-repeat behaviour.
REQ-031 With GAME_CONTROL_KEY_REPEAT_EN defined, a held key SHALL produce one move per WAIT expiry.
REQ-032 Without the macro, POLL SHALL act only on keys that were 0 at the previous POLL; a held key SHALL move once, and a key-history register SHALL be updated each POLL.

Structure
REQ-033 A shared package game_pkg SHALL hold the state enum, the direction encoding, the select constants (SEL_INIT=0, SEL_INC=1, SEL_DEC=2), and the colour constants.
REQ-034 One sub-module, key_arbiter, SHALL hold the combinational priority and eligibility logic, with inputs key, xpos, ypos and key-history, and outputs valid and dir.

Verification
REQ-035 Scenario: reset, then start pulse → INIT, then DRAW with plot=1 and s_color=1 exactly one cycle, then TCLR, then WAIT; busy=1 from INIT onward.
REQ-036 Scenario: xpos=80, ypos=100, key=4'b1000, timer_done pulse → ERASE (plot=1, s_color=0), then MOVE (en_xpos=1, s_xpos=1), then DRAW, at +2, +3 and +4 cycles respectively.
REQ-037 Scenario: xpos=0, key=4'b0101 (left and up), ypos=5 → up is chosen: en_ypos=1, s_ypos=2, en_xpos=0.
REQ-038 Scenario: ypos=Y_MAX, key=4'b0010 → POLL goes to TCLR, with no plot and no enables.
REQ-039 Scenario: key=4'b1000 held for three timer_done pulses → 3 moves with GAME_CONTROL_KEY_REPEAT_EN defined, 1 move without it.
REQ-040 Scenario: resetn=0 asynchronously during MOVE → within the same cycle en_xpos=0, plot=0 and busy=0; the FSM stays in IDLE until the next start.
